// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//
// Multi-cycle data-memory access controller that sits behind a single-cycle
// datapath. The ALU result is used as the byte address, the store operand as
// the write data, and the decoded memread/memwrite strobes as the request.
// The controller drives a request/acknowledge bus and returns load data to
// the memtoreg mux. stall holds the PC and the register-file write until the
// access has completed.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   memread     load requested by the current instruction
//   memwrite    store requested by the current instruction (wins over memread)
//   addr        byte address (ALU result)
//   writedata   store data
//   readdata    registered load data
//   stall       combinational; high while a requested access is incomplete
//   bus_req     registered bus request
//   bus_we      registered bus write enable (1 = write)
//   bus_addr    registered word address, low two bits forced to zero
//   bus_wdata   registered bus write data
//   bus_rdata   bus read data, valid in the bus_ack cycle
//   bus_ack     single-cycle completion pulse from the bus
//   err_timeout sticky; a bus access timed out
//   err_align   sticky; a misaligned access was attempted
//
// Parameters
//   TIMEOUT     BUSY cycles to wait for bus_ack before aborting (1..255)
//   ERR_DATA    value returned on readdata for a timed-out read
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        err_timeout,
  output logic        err_align
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Last counter value before the access is abandoned. The counter starts at
  // zero on the first BUSY cycle, so TIMEOUT BUSY cycles end at TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q,       state_d;
  logic [7:0]  cnt_q,         cnt_d;
  logic        bus_req_q,     bus_req_d;
  logic        bus_we_q,      bus_we_d;
  logic [31:0] bus_addr_q,    bus_addr_d;
  logic [31:0] bus_wdata_q,   bus_wdata_d;
  logic [31:0] readdata_q,    readdata_d;
  logic        err_timeout_q, err_timeout_d;
  logic        err_align_q,   err_align_d;

  logic        access_req;
  logic        aligned;

  assign access_req = memread | memwrite;
  assign aligned    = (addr[1:0] == 2'b00);

  // The core commits on the DONE edge, so stall drops there even though the
  // request strobes are still present.
  assign stall = access_req & (state_q != ST_DONE);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    readdata_d    = readdata_q;
    err_timeout_d = err_timeout_q;
    err_align_d   = err_align_q;

    unique case (state_q)
      ST_IDLE: begin
        // A stray bus_ack here is ignored: only the request strobes matter.
        if (access_req) begin
          if (aligned) begin
            bus_req_d   = 1'b1;
            // A simultaneous load and store is performed as a store.
            bus_we_d    = memwrite;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_wdata_d = writedata;
            cnt_d       = 8'd0;
            state_d     = ST_BUSY;
          end else begin
            // Misaligned: never touch the bus, finish in one stalled cycle.
            err_align_d = 1'b1;
            if (!memwrite) begin
              readdata_d = 32'd0;
            end
            state_d = ST_DONE;
          end
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // The ack is tested first so that an ack in the final timeout cycle
        // completes normally with no error.
        if (bus_ack) begin
          if (!bus_we_q) begin
            readdata_d = bus_rdata;
          end
          bus_req_d = 1'b0;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_req_d     = 1'b0;
          err_timeout_d = 1'b1;
          if (!bus_we_q) begin
            readdata_d = ERR_DATA;
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // One unstalled cycle for the core to commit, then accept the next
        // request in IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 32'd0;
      bus_wdata_q   <= 32'd0;
      readdata_q    <= 32'd0;
      err_timeout_q <= 1'b0;
      err_align_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      readdata_q    <= readdata_d;
      err_timeout_q <= err_timeout_d;
      err_align_q   <= err_align_d;
    end
  end

  assign readdata    = readdata_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign err_timeout = err_timeout_q;
  assign err_align   = err_align_q;

endmodule
